// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and widths for the SDRAM port arbiter
package sdram_arb_pkg;
    typedef enum logic [0:0] {ARB_IDLE, ARB_GRANT} arb_state_t;

    localparam int WORD_W = 32;
    localparam int BE_W   = 4;

    // Width of a requester id; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/sdram_arb_tag_fifo.sv
// rtl/sdram_arb_tag_fifo.sv - requester-id FIFO tracking reads in flight
module sdram_arb_tag_fifo #(
    parameter int DEPTH = 8,
    parameter int ID_W  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic            pop,
    output logic [ID_W-1:0] pop_id,
    output logic            full,
    output logic            empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ID_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty  = (count == '0);
    assign full   = (count == (PTR_W+1)'(DEPTH));
    assign do_pop = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push at full is still taken.
    assign do_push = push & (~full | do_pop);
    assign pop_id  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end
endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - multi-master arbiter for the SDRAM controller port; SDRAM_ARB_STATS_EN adds counters
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NUM_REQ         = 3,
    parameter int ADDR_W          = 25,
    parameter int HOLD_MAX        = 8,
    parameter int MAX_OUTSTANDING = 8,
    parameter int FIXED_PRIO0     = 1
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ-1:0]        req_read,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*WORD_W-1:0] req_writedata,
    input  logic [NUM_REQ*BE_W-1:0]   req_byteenable,
    output logic [NUM_REQ-1:0]        req_waitrequest,
    output logic [WORD_W-1:0]         req_readdata,
    output logic [NUM_REQ-1:0]        req_readdatavalid,
    output logic [ADDR_W-1:0]         m_address,
    output logic                      m_read,
    output logic                      m_write,
    output logic [WORD_W-1:0]         m_writedata,
    output logic [BE_W-1:0]           m_byteenable,
    input  logic                      m_waitrequest,
    input  logic [WORD_W-1:0]         m_readdata,
    input  logic                      m_readdatavalid,
    output logic                      err_orphan
`ifdef SDRAM_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]     stat_grants,
    output logic [NUM_REQ*32-1:0]     stat_stall
`endif
);
    localparam int ID_W   = id_w(NUM_REQ);
    localparam int LO     = (FIXED_PRIO0 != 0) ? 1 : 0;
    localparam int SPAN   = NUM_REQ - LO;
    localparam int BEAT_W = $clog2(HOLD_MAX + 1);

    typedef logic [ID_W-1:0] id_t;

    arb_state_t        state;
    id_t               g;
    id_t               rr_ptr;
    id_t               rr_next;
    id_t               win_idx;
    id_t               cand;
    id_t               pop_id;
    logic              win_any;
    logic [BEAT_W-1:0] beats;
    logic [BEAT_W-1:0] beats_next;
    logic [NUM_REQ-1:0] active;
    logic              in_grant;
    logic              g_read;
    logic              g_write;
    logic              read_block;
    logic              accepted;
    logic              pending;
    logic              leave;
    logic              fifo_full;
    logic              fifo_empty;

    assign active     = req_read | req_write;
    assign in_grant   = (state == ARB_GRANT);
    assign g_read     = in_grant & req_read[g];
    assign g_write    = in_grant & req_write[g];
    assign read_block = fifo_full & g_read;

    assign m_read       = g_read & ~read_block;
    assign m_write      = g_write;
    assign m_address    = in_grant ? req_address[g*ADDR_W +: ADDR_W] : '0;
    assign m_writedata  = in_grant ? req_writedata[g*WORD_W +: WORD_W] : '0;
    assign m_byteenable = in_grant ? req_byteenable[g*BE_W +: BE_W] : '0;

    assign accepted   = (m_read | m_write) & ~m_waitrequest;
    assign pending    = (m_read | m_write) & m_waitrequest;
    assign beats_next = beats + BEAT_W'(accepted);
    // Requester 0 may only cut in between transfers, never under a held one.
    assign leave = ~(req_read[g] | req_write[g])
                 | (beats_next == BEAT_W'(HOLD_MAX))
                 | ((FIXED_PRIO0 != 0) & (g != '0) & active[0] & ~pending);
    assign rr_next = (int'(g) + 1 >= NUM_REQ) ? id_t'(LO) : id_t'(int'(g) + 1);

    always_comb begin
        req_waitrequest = '1;
        if (in_grant) begin
            req_waitrequest[g] = m_waitrequest | read_block;
        end
    end

    // Scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int k = SPAN - 1; k >= 0; k--) begin
            cand = id_t'(LO + ((int'(rr_ptr) - LO + k) % SPAN));
            if (active[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
        if ((FIXED_PRIO0 != 0) && active[0]) begin
            win_any = 1'b1;
            win_idx = '0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state  <= ARB_IDLE;
            g      <= '0;
            beats  <= '0;
            rr_ptr <= id_t'(1);
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (win_any) begin
                        g     <= win_idx;
                        beats <= '0;
                        state <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    beats <= beats_next;
                    if (leave) begin
                        state <= ARB_IDLE;
                        if (g != '0 || FIXED_PRIO0 == 0) begin
                            rr_ptr <= rr_next;
                        end
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    sdram_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .ID_W  (ID_W)
    ) u_tag_fifo (
        .clk     (clk_clk),
        .rst     (reset_reset),
        .push    (accepted & m_read),
        .push_id (g),
        .pop     (m_readdatavalid),
        .pop_id  (pop_id),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            req_readdatavalid <= '0;
            req_readdata      <= '0;
            err_orphan        <= 1'b0;
        end else begin
            req_readdatavalid <= '0;
            if (m_readdatavalid && !fifo_empty) begin
                req_readdatavalid[pop_id] <= 1'b1;
                req_readdata              <= m_readdata;
            end
            if (m_readdatavalid && fifo_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

`ifdef SDRAM_ARB_STATS_EN
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            stat_grants <= '0;
            stat_stall  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (accepted && int'(g) == i) begin
                    stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
                end
                if (active[i] && req_waitrequest[i]) begin
                    stat_stall[i*32 +: 32] <= stat_stall[i*32 +: 32] + 32'd1;
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - scoreboard bench for sdram_port_arbiter
module tb_sdram_port_arbiter;
    localparam int N  = 3;
    localparam int AW = 25;

    logic              clk_clk = 1'b0;
    logic              reset_reset;
    logic [N*AW-1:0]   req_address;
    logic [N-1:0]      req_read;
    logic [N-1:0]      req_write;
    logic [N*32-1:0]   req_writedata;
    logic [N*4-1:0]    req_byteenable;
    logic [N-1:0]      req_waitrequest;
    logic [31:0]       req_readdata;
    logic [N-1:0]      req_readdatavalid;
    logic [AW-1:0]     m_address;
    logic              m_read;
    logic              m_write;
    logic [31:0]       m_writedata;
    logic [3:0]        m_byteenable;
    logic              m_waitrequest;
    logic [31:0]       m_readdata;
    logic              m_readdatavalid;
    logic              err_orphan;
`ifdef SDRAM_ARB_STATS_EN
    logic [N*32-1:0]   stat_grants;
    logic [N*32-1:0]   stat_stall;
`endif

    typedef struct {
        logic [N-1:0] owner;
        logic [31:0]  data;
    } exp_t;
    typedef struct {
        logic [31:0] data;
        int          due;
    } pend_t;

    exp_t  expq[$];
    pend_t pend_q[$];
    int    n_vec = 0;
    int    n_miss = 0;
    int    cyc = 0;
    int    orphan_req = 0;
    int    orphan_done = 0;
    bit    withhold = 1'b0;

    sdram_port_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .HOLD_MAX(8), .MAX_OUTSTANDING(8), .FIXED_PRIO0(1)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset),
        .req_address(req_address), .req_read(req_read), .req_write(req_write),
        .req_writedata(req_writedata), .req_byteenable(req_byteenable),
        .req_waitrequest(req_waitrequest), .req_readdata(req_readdata),
        .req_readdatavalid(req_readdatavalid),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid),
        .err_orphan(err_orphan)
`ifdef SDRAM_ARB_STATS_EN
        , .stat_grants(stat_grants), .stat_stall(stat_stall)
`endif
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // SDRAM controller model: 3-cycle read latency, data derived from the address.
    initial begin
        m_waitrequest   = 1'b0;
        m_readdatavalid = 1'b0;
        m_readdata      = '0;
        forever begin
            @(negedge clk_clk);
            if (reset_reset) pend_q.delete();
            else if (m_read && !m_waitrequest)
                pend_q.push_back('{data: {16'hCAFE, m_address[19:4]}, due: cyc + 3});
            @(posedge clk_clk);
            cyc++;
            #1;
            m_readdatavalid = 1'b0;
            if (orphan_req != orphan_done) begin
                m_readdatavalid = 1'b1;
                m_readdata      = 32'hDEAD_BEEF;
                orphan_done++;
            end else if (!withhold && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                m_readdatavalid = 1'b1;
                m_readdata      = pend_q[0].data;
                void'(pend_q.pop_front());
            end
        end
    end

    // Monitor: every read-return pulse must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_clk);
            if (reset_reset) expq.delete();
            else if (req_readdatavalid != '0) begin
                if (expq.size() == 0) check("rdv_unexpected", 32'(req_readdatavalid), 32'd0);
                else begin
                    e = expq.pop_front();
                    check("rdv_owner", 32'(req_readdatavalid), 32'(e.owner));
                    check("rdv_data", req_readdata, e.data);
                end
            end
        end
    end

    task automatic step(output logic [N-1:0] wr);
        @(negedge clk_clk);
        wr = req_waitrequest;
        @(posedge clk_clk);
        #1;
    endtask

    task automatic do_read(input int r, input logic [AW-1:0] a, input logic [31:0] d);
        int n = 0;
        req_address[r*AW +: AW] = a;
        req_read[r] = 1'b1;
        @(negedge clk_clk);
        while (req_waitrequest[r] === 1'b1 && n < 50) begin
            @(negedge clk_clk);
            n++;
        end
        check("rd_accept", 32'(n < 50), 32'd1);
        if (n < 50) expq.push_back('{owner: N'(1) << r, data: d});
        @(posedge clk_clk);
        #1;
        req_read[r] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(negedge clk_clk);
            n++;
        end
        check("drain", 32'(expq.size()), 32'd0);
        @(posedge clk_clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] wr;
        logic [N-1:0] ew;
`ifdef SDRAM_ARB_STATS_EN
        logic [N*32-1:0] g0;
`endif
        req_address = '0; req_read = '0; req_write = '0;
        req_writedata = {N{32'h1234_5678}}; req_byteenable = '1;
        reset_reset = 1'b1;
        repeat (3) @(posedge clk_clk);
        #1 reset_reset = 1'b0;
        @(negedge clk_clk);
        check("rst_wait", 32'(req_waitrequest), 32'h7);
        check("rst_rdv", 32'(req_readdatavalid), 32'd0);
        check("rst_rdata", req_readdata, 32'd0);
        check("rst_mstrobe", {30'd0, m_read, m_write}, 32'd0);
        check("rst_orphan", 32'(err_orphan), 32'd0);
        @(posedge clk_clk);
        #1;

        do_read(1, 25'h10, 32'hCAFE0001);
        drain();

        req_address[0 +: AW] = 25'h100;
        req_address[AW +: AW] = 25'h200;
        req_write = 3'b011;
        step(wr); check("prio_idle", 32'(wr), 32'h7);
        step(wr); check("prio_req0_first", 32'(wr), 32'h6);
        step(wr); check("prio_req0_hold", 32'(wr), 32'h6);
        req_write[0] = 1'b0;
        step(wr); check("prio_release", 32'(wr), 32'h6);
        step(wr); check("prio_idle2", 32'(wr), 32'h7);
        step(wr); check("prio_req1_next", 32'(wr), 32'h5);
        step(wr); check("preempt_burst", 32'(wr), 32'h5);
        req_write[0] = 1'b1;
        step(wr); check("preempt_boundary", 32'(wr), 32'h5);
        step(wr); check("preempt_idle", 32'(wr), 32'h7);
        step(wr); check("preempt_req0", 32'(wr), 32'h6);
        req_write = '0;
        step(wr); check("drop_all", 32'(wr), 32'h6);

`ifdef SDRAM_ARB_STATS_EN
        g0 = stat_grants;
`endif
        req_address[2*AW +: AW] = 25'h300;
        req_write = 3'b110;
        for (int c = 0; c < 36; c++) begin
            step(wr);
            if (c % 9 == 0) ew = 3'b111;
            else if ((c / 9) % 2 == 0) ew = 3'b011;
            else ew = 3'b101;
            check("rr_wait", 32'(wr), 32'(ew));
        end
        req_write = '0;
`ifdef SDRAM_ARB_STATS_EN
        check("stat_req1", stat_grants[32 +: 32] - g0[32 +: 32], 32'd16);
        check("stat_req2", stat_grants[64 +: 32] - g0[64 +: 32], 32'd16);
`endif
        step(wr);

        withhold = 1'b1;
        for (int i = 0; i < 8; i++)
            do_read(i % 3, 25'h1000 + 25'(16 * i), 32'hCAFE0100 + 32'(i));
        req_address[2*AW +: AW] = 25'h1080;
        req_read[2] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(wr);
            check("full_block", 32'(wr[2]), 32'd1);
        end
        withhold = 1'b0;
        begin
            int n = 0;
            @(negedge clk_clk);
            while (req_waitrequest[2] === 1'b1 && n < 50) begin
                @(negedge clk_clk);
                n++;
            end
            check("ninth_accept", 32'(n < 50), 32'd1);
            if (n < 50) expq.push_back('{owner: 3'b100, data: 32'hCAFE0108});
            @(posedge clk_clk);
            #1 req_read[2] = 1'b0;
        end
        drain();

        orphan_req++;
        repeat (3) step(wr);
        check("orphan_set", 32'(err_orphan), 32'd1);
        repeat (2) step(wr);
        check("orphan_sticky", 32'(err_orphan), 32'd1);

        withhold = 1'b1;
        for (int i = 0; i < 4; i++)
            do_read(2, 25'h2000 + 25'(16 * i), 32'hCAFE0200 + 32'(i));
        req_read[2] = 1'b1;
        reset_reset = 1'b1;
        step(wr);
        reset_reset = 1'b0;
        req_read = '0;
        withhold = 1'b0;
        @(negedge clk_clk);
        check("mrst_wait", 32'(req_waitrequest), 32'h7);
        check("mrst_rdv", 32'(req_readdatavalid), 32'd0);
        check("mrst_rdata", req_readdata, 32'd0);
        check("mrst_orphan", 32'(err_orphan), 32'd0);
        check("mrst_mread", 32'(m_read), 32'd0);
        @(posedge clk_clk);
        #1;
        do_read(0, 25'h40, 32'hCAFE0004);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
